mult_div_unit: RTL

Iterative multiply/divide unit for the multicycle MIPS datapath, owning the HI and LO registers. It consumes the two register-file read operands (rs → op_a, rt → op_b) for MULT, MULTU, DIV and DIVU. It also accepts MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO writeback. The control FSM starts an operation, stalls on busy, and resumes on done.

---
 rtl/mult_div_unit_pkg.sv | 25 ++
 rtl/mult_div_unit_if.sv | 28 ++
 rtl/mult_div_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared constants for the MIPS multiply/divide unit
// Package mips_pkg: op encodings, iteration count, FSM state type and an
// absolute-value helper used when latching signed operands.
package mips_pkg;

   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   localparam int MD_ITER = 32;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2
   } md_state_t;

   // Two's-complement magnitude; 0x80000000 maps to itself, which is the
   // correct unsigned magnitude.
   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle of the multiply/divide unit
// master: datapath control side (drives start/op/operands/hi_we/lo_we).
// slave : mult_div_unit (drives busy/done/div_by_zero/hi_out/lo_out).
interface mult_div_unit_if;

   logic        start;
   logic [1:0]  op;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        hi_we;
   logic        lo_we;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   modport master (
      output start, op, op_a, op_b, hi_we, lo_we,
      input  busy, done, div_by_zero, hi_out, lo_out
   );

   modport slave (
      input  start, op, op_a, op_b, hi_we, lo_we,
      output busy, done, div_by_zero, hi_out, lo_out
   );

endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI and LO
// Ports: clk, reset_n (async, active-low), md (mult_div_unit_if.slave):
//   start/op/op_a/op_b launch an operation while idle; hi_we/lo_we perform
//   MTHI/MTLO from op_a; busy, done, div_by_zero report progress; hi_out and
//   lo_out are the registered HI/LO values.
module mult_div_unit
   import mips_pkg::*;
(
   input logic          clk,
   input logic          reset_n,
   mult_div_unit_if.slave md
);

   md_state_t   state, state_nxt;
   logic [4:0]  count;
   logic [63:0] acc;        // product, or {remainder, quotient} when dividing
   logic [31:0] reg_a;      // multiplicand, or dividend shifted out MSB first
   logic [31:0] reg_b;      // multiplier shifted out LSB first, or divisor
   logic        is_div;
   logic        neg_q;      // sign of product / quotient
   logic        neg_r;      // sign of remainder (follows the dividend)
   logic        zero_flag;
   logic [31:0] hi_r, lo_r;
   logic        done_r, dbz_r;

   logic        signed_op, sign_a, sign_b, div_zero_req;
   logic [32:0] mul_sum, div_trial, div_diff;
   logic        div_ge;
   logic [63:0] prod_fix;
   logic [31:0] quot_fix, rem_fix;

   assign signed_op    = (md.op == MD_MULT) || (md.op == MD_DIV);
   assign sign_a       = signed_op & md.op_a[31];
   assign sign_b       = signed_op & md.op_b[31];
   assign div_zero_req = md.op[1] && (md.op_b == 32'd0);

   // Shift-add step: add the multiplicand into the upper half, then shift the
   // 33-bit sum (with carry) down into the accumulator.
   assign mul_sum = {1'b0, acc[63:32]} + {1'b0, (reg_b[0] ? reg_a : 32'd0)};

   // Restoring step: trial remainder never exceeds 2*divisor-1, so bit 32 of
   // the difference is a clean borrow.
   assign div_trial = {acc[63:32], reg_a[31]};
   assign div_diff  = div_trial - {1'b0, reg_b};
   assign div_ge    = ~div_diff[32];

   assign prod_fix = neg_q ? (~acc + 64'd1) : acc;
   assign quot_fix = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
   assign rem_fix  = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];

   always_comb begin
      state_nxt = state;
      case (state)
         MD_IDLE: if (md.start) state_nxt = div_zero_req ? MD_FIX : MD_CALC;
         MD_CALC: if (count == 5'(MD_ITER - 1)) state_nxt = MD_FIX;
         MD_FIX:  state_nxt = MD_IDLE;
         default: state_nxt = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= MD_IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count     <= '0;
         acc       <= '0;
         reg_a     <= '0;
         reg_b     <= '0;
         is_div    <= 1'b0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         zero_flag <= 1'b0;
         hi_r      <= '0;
         lo_r      <= '0;
         done_r    <= 1'b0;
         dbz_r     <= 1'b0;
      end else begin
         done_r <= 1'b0;
         dbz_r  <= 1'b0;
         case (state)
            MD_IDLE: begin
               if (md.start) begin
                  reg_a     <= sign_a ? abs32(md.op_a) : md.op_a;
                  reg_b     <= sign_b ? abs32(md.op_b) : md.op_b;
                  is_div    <= md.op[1];
                  neg_q     <= sign_a ^ sign_b;
                  neg_r     <= sign_a;
                  zero_flag <= div_zero_req;
                  acc       <= '0;
                  count     <= '0;
               end else begin
                  if (md.hi_we) hi_r <= md.op_a;
                  if (md.lo_we) lo_r <= md.op_a;
               end
            end
            MD_CALC: begin
               count <= count + 5'd1;
               if (is_div) begin
                  acc   <= {(div_ge ? div_diff[31:0] : div_trial[31:0]), acc[30:0], div_ge};
                  reg_a <= {reg_a[30:0], 1'b0};
               end else begin
                  acc   <= {mul_sum, acc[31:1]};
                  reg_b <= {1'b0, reg_b[31:1]};
               end
            end
            MD_FIX: begin
               done_r <= 1'b1;
               if (zero_flag) begin
                  dbz_r <= 1'b1;
               end else if (is_div) begin
                  hi_r <= rem_fix;
                  lo_r <= quot_fix;
               end else begin
                  hi_r <= prod_fix[63:32];
                  lo_r <= prod_fix[31:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign md.busy        = (state != MD_IDLE);
   assign md.done        = done_r;
   assign md.div_by_zero = dbz_r;
   assign md.hi_out      = hi_r;
   assign md.lo_out      = lo_r;

endmodule
